bitty_seq_ctrl: RTL and testbench
=================================

Name: bitty_seq_ctrl

Overview:
Instruction sequencer for the bitty core. Owns the program counter and drives the fetch address to instruction memory. Waits out the synchronous memory latency, latches the instruction, pulses the core's run input, and commits the branch-logic next PC when the core reports done. Replaces the free-running 4-state run FSM at the top level and adds single-step, stop request, a done-timeout fault and an instruction counter.

Parameters:
ADDR_W, 8, PC / memory address width
MEM_LAT, 1, instruction memory read latency in cycles (>=1)
TIMEOUT, 64, maximum EXEC cycles waiting for core_done before FAULT (>=2)
RESET_PC, 0, PC value after reset and after restart from FAULT

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  reset; asynchronous, active-low
start  in  1  level sampled; begins or resumes execution from IDLE or FAULT
stop  in  1  request halt after the current instruction commits
step_mode  in  1  when 1, pause after each commit
step  in  1  in PAUSE, execute one more instruction
mem_addr  out  ADDR_W  instruction memory address (= PC)
instr_in  in  16  instruction memory read data
instr_out  out  16  latched instruction to core d_instr
core_run  out  1  one-cycle run pulse to core
core_done  in  1  core completion strobe
next_pc  in  ADDR_W  branch-logic result for the committed instruction
busy  out  1  1 in FETCH/MEMWAIT/ISSUE/EXEC/COMMIT
paused  out  1  1 in PAUSE
fault  out  1  1 in FAULT
instr_count  out  16  committed instruction count

Behaviour:
- Async reset (rst_n=0): state=IDLE, pc=RESET_PC, instr_out=0, instr_count=0, stop_pend=0, wait counters=0. All status outputs and core_run are 0.
- mem_addr = pc at all times. core_run = (state==ISSUE). busy, paused and fault decode from the state.
- States and transitions:
  - IDLE: start=1 -> FETCH. The PC is kept, so execution resumes. stop is ignored.
  - FETCH: 1 cycle -> MEMWAIT.
  - MEMWAIT: stays MEM_LAT cycles, then -> ISSUE. During ISSUE, instr_in is valid and is latched into instr_out at the ISSUE edge.
  - ISSUE: core_run=1 for exactly 1 cycle -> EXEC. Clears the timeout counter.
  - EXEC: core_done=1 -> COMMIT. Otherwise the counter increments. If counter==TIMEOUT-1 and core_done=0 -> FAULT. A done arriving in EXEC cycle TIMEOUT-1 (0-based) is still accepted.
  - COMMIT: pc<=next_pc and instr_count<=instr_count+1. Next state by priority:
    - stop_pend -> IDLE (clears stop_pend)
    - step_mode -> PAUSE
    - else -> FETCH
  - PAUSE: priority stop -> IDLE, then step=1 -> FETCH, else stay. stop_pend is cleared here.
  - FAULT: sticky. start=1 -> pc<=RESET_PC, stop_pend<=0, -> FETCH. instr_count is kept.
- stop_pend is set when stop=1 in FETCH/MEMWAIT/ISSUE/EXEC/COMMIT. A stop asserted in the COMMIT cycle takes effect in that same COMMIT.
- core_done outside EXEC is ignored. It does not change state or count.
- start is ignored outside IDLE and FAULT.
- step is ignored outside PAUSE. step is level-sampled, so the source must supply a pulse.
- Wrap rules:
  - pc takes next_pc unmodified, so wrap-around is the branch logic's responsibility.
  - instr_count wraps 0xFFFF -> 0x0000.
- Latency, fresh start with MEM_LAT=1 and done on the first EXEC cycle:
  - start sampled at edge 0
  - FETCH cycle 1, MEMWAIT 2, ISSUE 3, EXEC 4, COMMIT 5
  - next FETCH at cycle 6, i.e. 5 cycles per instruction minimum.
- rst_n low mid-operation: immediate return to reset values. A core_run pulse in progress drops asynchronously.

Optional Feature:
Macro BITTY_SEQ_BREAKPOINT_EN.
- Defined: adds ports bp_en (in 1), bp_addr (in ADDR_W) and bp_hit (out 1).
  - In FETCH, if bp_en=1 and pc==bp_addr, the block enters PAUSE instead of MEMWAIT and sets bp_hit.
  - A subsequent step fetches that same address normally; the breakpoint is not re-checked for the FETCH entered from PAUSE via step.
  - bp_hit clears on leaving PAUSE and on reset.
- Undefined: ports absent, and FETCH always goes to MEMWAIT.

Test Plan:
- Reset then start=1 for 1 cycle, with instr_in=0x1234 at addr 0, core_done on the first EXEC cycle and next_pc=0x01 -> core_run high in cycle 3 only, instr_out=0x1234, mem_addr=0x01 after cycle 5, instr_count=1.
- Run 3 instructions, next_pc = pc+1, with stop pulsed during the 2nd EXEC -> 2nd commits, state=IDLE, pc=0x02, instr_count=2. Then start -> resumes fetch at 0x02.
- step_mode=1, start -> paused=1 after 1 commit with instr_count=1. step pulse -> exactly one more commit, paused=1, instr_count=2.
- core_done never asserted, TIMEOUT=64 -> fault=1 after 64 EXEC cycles, pc unchanged. start -> mem_addr=RESET_PC and busy=1. In a separate run, done on EXEC cycle 63 -> COMMIT, no fault.
- Spurious core_done pulsed in IDLE, FETCH and PAUSE -> no state or counter change. Separately, rst_n low during EXEC -> core_run=0, busy=0, pc=0, instr_count=0 immediately.
- With BITTY_SEQ_BREAKPOINT_EN, bp_en=1, bp_addr=0x02 and linear code -> pause with bp_hit=1 and instr_count=2. step -> fetch 0x02 executes, next_pc=0x03.

Source files
------------

// File: rtl/bitty_seq_ctrl.sv
// bitty_seq_ctrl: instruction sequencer for the bitty core.
// It owns the PC, fetches from synchronous instruction memory, and issues one
// instruction at a time to the core. It supports single-step, stop requests,
// a done-timeout fault and a committed-instruction counter.
// Optional breakpoint support is enabled by defining BITTY_SEQ_BREAKPOINT_EN.
module bitty_seq_ctrl #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              step_mode,
  input  logic              step,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       instr_in,
  output logic [15:0]       instr_out,
  output logic              core_run,
  input  logic              core_done,
  input  logic [ADDR_W-1:0] next_pc,
  output logic              busy,
  output logic              paused,
  output logic              fault,
`ifdef BITTY_SEQ_BREAKPOINT_EN
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              bp_hit,
`endif
  output logic [15:0]       instr_count
);

  localparam int unsigned WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_MEMWAIT, S_ISSUE, S_EXEC, S_COMMIT, S_PAUSE, S_FAULT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [15:0]         instr_q, instr_d;
  logic [15:0]         count_q, count_d;
  logic                stop_pend_q, stop_pend_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [TO_W-1:0]     tmo_q, tmo_d;
`ifdef BITTY_SEQ_BREAKPOINT_EN
  logic                bp_skip_q, bp_skip_d;
  logic                bp_hit_q, bp_hit_d;
`endif

  assign mem_addr    = pc_q;
  assign instr_out   = instr_q;
  assign instr_count = count_q;
`ifdef BITTY_SEQ_BREAKPOINT_EN
  assign bp_hit      = bp_hit_q;
`endif

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    count_d     = count_q;
    stop_pend_d = stop_pend_q;
    wait_d      = wait_q;
    tmo_d       = tmo_q;
`ifdef BITTY_SEQ_BREAKPOINT_EN
    bp_skip_d   = bp_skip_q;
    bp_hit_d    = bp_hit_q;
`endif

    // A stop while an instruction is in flight is remembered until commit.
    if (stop && (state_q inside {S_FETCH, S_MEMWAIT, S_ISSUE, S_EXEC, S_COMMIT})) begin
      stop_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        wait_d  = '0;
        state_d = S_MEMWAIT;
`ifdef BITTY_SEQ_BREAKPOINT_EN
        bp_skip_d = 1'b0;
        if (bp_en && (pc_q == bp_addr) && !bp_skip_q) begin
          state_d  = S_PAUSE;
          bp_hit_d = 1'b1;
        end
`endif
      end
      S_MEMWAIT: begin
        if (wait_q == WAIT_W'(MEM_LAT - 1)) state_d = S_ISSUE;
        else                                 wait_d  = wait_q + WAIT_W'(1);
      end
      S_ISSUE: begin
        instr_d = instr_in;
        tmo_d   = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (core_done)                          state_d = S_COMMIT;
        else if (tmo_q == TO_W'(TIMEOUT - 1))   state_d = S_FAULT;
        else                                    tmo_d   = tmo_q + TO_W'(1);
      end
      S_COMMIT: begin
        pc_d    = next_pc;
        count_d = count_q + 16'd1;
        if (stop_pend_q || stop) begin
          stop_pend_d = 1'b0;
          state_d     = S_IDLE;
        end else if (step_mode) begin
          state_d = S_PAUSE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_PAUSE: begin
        stop_pend_d = 1'b0;
        if (stop) begin
          state_d = S_IDLE;
        end else if (step) begin
          state_d = S_FETCH;
`ifdef BITTY_SEQ_BREAKPOINT_EN
          bp_skip_d = 1'b1;
`endif
        end
`ifdef BITTY_SEQ_BREAKPOINT_EN
        if (stop || step) bp_hit_d = 1'b0;
`endif
      end
      S_FAULT: begin
        if (start) begin
          pc_d        = ADDR_W'(RESET_PC);
          stop_pend_d = 1'b0;
          state_d     = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered status decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= ADDR_W'(RESET_PC);
      instr_q     <= '0;
      count_q     <= '0;
      stop_pend_q <= 1'b0;
      wait_q      <= '0;
      tmo_q       <= '0;
      core_run    <= 1'b0;
      busy        <= 1'b0;
      paused      <= 1'b0;
      fault       <= 1'b0;
`ifdef BITTY_SEQ_BREAKPOINT_EN
      bp_skip_q   <= 1'b0;
      bp_hit_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      count_q     <= count_d;
      stop_pend_q <= stop_pend_d;
      wait_q      <= wait_d;
      tmo_q       <= tmo_d;
      core_run    <= (state_d == S_ISSUE);
      busy        <= (state_d inside {S_FETCH, S_MEMWAIT, S_ISSUE, S_EXEC, S_COMMIT});
      paused      <= (state_d == S_PAUSE);
      fault       <= (state_d == S_FAULT);
`ifdef BITTY_SEQ_BREAKPOINT_EN
      bp_skip_q   <= bp_skip_d;
      bp_hit_q    <= bp_hit_d;
`endif
    end
  end

endmodule

// File: tb/tb_bitty_seq_ctrl.sv
// Testbench for bitty_seq_ctrl. It uses a behavioural memory and core responder,
// and checks the DUT against a transaction-level PC/count model.
module tb_bitty_seq_ctrl;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned MEM_LAT = 1;
  localparam int unsigned TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst_n, start, stop, step_mode, step, core_done;
  logic [ADDR_W-1:0] mem_addr, next_pc;
  logic [15:0]       instr_in, instr_out, instr_count;
  logic              core_run, busy, paused, fault;
`ifdef BITTY_SEQ_BREAKPOINT_EN
  logic              bp_en, bp_hit;
  logic [ADDR_W-1:0] bp_addr;
`endif

  logic [15:0] mem [256];
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  exp_pc;
  logic [15:0] exp_cnt;

  assign instr_in = mem[mem_addr];
  always #5 clk = ~clk;

  bitty_seq_ctrl #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .TIMEOUT(TIMEOUT), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step_mode(step_mode),
    .step(step), .mem_addr(mem_addr), .instr_in(instr_in), .instr_out(instr_out),
    .core_run(core_run), .core_done(core_done), .next_pc(next_pc), .busy(busy),
    .paused(paused), .fault(fault),
`ifdef BITTY_SEQ_BREAKPOINT_EN
    .bp_en(bp_en), .bp_addr(bp_addr), .bp_hit(bp_hit),
`endif
    .instr_count(instr_count)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    start = 0; stop = 0; step_mode = 0; step = 0; core_done = 0; next_pc = '0;
`ifdef BITTY_SEQ_BREAKPOINT_EN
    bp_en = 0; bp_addr = '0;
`endif
    rst_n = 0; tick; tick; rst_n = 1;
    exp_pc = 8'h00; exp_cnt = 16'h0000;
  endtask

  task automatic pulse_start;
    start = 1; tick; start = 0;
  endtask

  // Core responder: waits for the run pulse, answers done after dly EXEC
  // cycles and returns at the negedge of the cycle after COMMIT.
  task automatic core_exec(input int dly, input logic [7:0] npc, input bit stop_in_exec,
                           output bit ok, output int waited, output logic [15:0] seen);
    ok = 0; waited = 0; seen = 16'hxxxx;
    for (int i = 0; i < 200; i++) begin
      if (core_run === 1'b1) begin ok = 1; break; end
      tick; waited++;
    end
    if (!ok) return;
    tick;
    seen = instr_out;
    if (stop_in_exec) stop = 1;
    for (int k = 0; k < dly; k++) begin tick; stop = 0; end
    core_done = 1; next_pc = npc;
    tick;
    stop = 0; core_done = 0;
    tick;
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_cmp++; if (paused !== 1'b0)  begin n_bad++; $display("FAIL reset_paused: got %b exp 0", paused); end
    n_cmp++; if (fault !== 1'b0)   begin n_bad++; $display("FAIL reset_fault: got %b exp 0", fault); end
    n_cmp++; if (core_run !== 1'b0) begin n_bad++; $display("FAIL reset_run: got %b exp 0", core_run); end
    n_cmp++; if (mem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_pc: got %h exp 00", mem_addr); end
    n_cmp++; if (instr_out !== 16'h0) begin n_bad++; $display("FAIL reset_instr: got %h exp 0000", instr_out); end
    n_cmp++; if (instr_count !== 16'h0) begin n_bad++; $display("FAIL reset_count: got %h exp 0000", instr_count); end
  endtask

  task automatic test_latency;
    bit ok; int w; logic [15:0] seen;
    do_reset;
    mem[0] = 16'h1234;
    pulse_start;
    n_cmp++; if (core_run !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL lat_c1: run %b busy %b exp 0 1", core_run, busy); end
    tick;
    n_cmp++; if (core_run !== 1'b0) begin n_bad++; $display("FAIL lat_c2: run %b exp 0", core_run); end
    tick;
    n_cmp++; if (core_run !== 1'b1) begin n_bad++; $display("FAIL lat_c3: run %b exp 1", core_run); end
    tick;
    n_cmp++; if (core_run !== 1'b0) begin n_bad++; $display("FAIL lat_c4: run %b exp 0", core_run); end
    core_done = 1; next_pc = 8'h01;
    tick;
    core_done = 0;
    n_cmp++; if (mem_addr !== 8'h00) begin n_bad++; $display("FAIL lat_c5_pc: got %h exp 00", mem_addr); end
    tick;
    n_cmp++; if (mem_addr !== 8'h01) begin n_bad++; $display("FAIL lat_c6_pc: got %h exp 01", mem_addr); end
    n_cmp++; if (instr_count !== 16'd1) begin n_bad++; $display("FAIL lat_count: got %0d exp 1", instr_count); end
    n_cmp++; if (instr_out !== 16'h1234) begin n_bad++; $display("FAIL lat_instr: got %h exp 1234", instr_out); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL lat_refetch: busy %b exp 1", busy); end
    core_exec(0, 8'h02, 1'b1, ok, w, seen);
    n_cmp++; if (!ok || busy !== 1'b0) begin n_bad++; $display("FAIL lat_stop: ok %0d busy %b exp 1 0", ok, busy); end
  endtask

  task automatic test_stop;
    bit ok; int w; logic [15:0] seen;
    do_reset;
    for (int a = 0; a < 4; a++) mem[a] = 16'(16'hA000 + a);
    pulse_start;
    core_exec($urandom_range(0, 5), 8'h01, 1'b0, ok, w, seen);
    core_exec($urandom_range(0, 5), 8'h02, 1'b1, ok, w, seen);
    n_cmp++; if (!ok || seen !== 16'hA001) begin n_bad++; $display("FAIL stop_instr2: got %h exp a001", seen); end
    n_cmp++; if (busy !== 1'b0 || paused !== 1'b0) begin n_bad++; $display("FAIL stop_idle: busy %b paused %b exp 0 0", busy, paused); end
    n_cmp++; if (mem_addr !== 8'h02) begin n_bad++; $display("FAIL stop_pc: got %h exp 02", mem_addr); end
    n_cmp++; if (instr_count !== 16'd2) begin n_bad++; $display("FAIL stop_count: got %0d exp 2", instr_count); end
    tick; tick; tick;
    n_cmp++; if (busy !== 1'b0 || instr_count !== 16'd2) begin n_bad++; $display("FAIL stop_hold: busy %b count %0d exp 0 2", busy, instr_count); end
    pulse_start;
    n_cmp++; if (busy !== 1'b1 || mem_addr !== 8'h02) begin n_bad++; $display("FAIL stop_resume: busy %b pc %h exp 1 02", busy, mem_addr); end
    core_exec(1, 8'h03, 1'b1, ok, w, seen);
    n_cmp++; if (!ok || seen !== 16'hA002) begin n_bad++; $display("FAIL stop_resume_instr: got %h exp a002", seen); end
  endtask

  task automatic test_step;
    bit ok; int w; logic [15:0] seen;
    do_reset;
    step_mode = 1;
    pulse_start;
    core_exec($urandom_range(0, 4), 8'h10, 1'b0, ok, w, seen);
    n_cmp++; if (!ok || paused !== 1'b1 || instr_count !== 16'd1) begin n_bad++; $display("FAIL step_first: paused %b count %0d exp 1 1", paused, instr_count); end
    tick; tick; tick;
    n_cmp++; if (paused !== 1'b1 || core_run !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL step_hold: paused %b run %b busy %b exp 1 0 0", paused, core_run, busy); end
    step = 1; tick; step = 0;
    n_cmp++; if (busy !== 1'b1 || mem_addr !== 8'h10) begin n_bad++; $display("FAIL step_fetch: busy %b pc %h exp 1 10", busy, mem_addr); end
    core_exec($urandom_range(0, 4), 8'h11, 1'b0, ok, w, seen);
    n_cmp++; if (!ok || paused !== 1'b1 || instr_count !== 16'd2) begin n_bad++; $display("FAIL step_second: paused %b count %0d exp 1 2", paused, instr_count); end
    n_cmp++; if (mem_addr !== 8'h11) begin n_bad++; $display("FAIL step_pc: got %h exp 11", mem_addr); end
    step_mode = 0; stop = 1; tick; stop = 0;
    n_cmp++; if (paused !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL step_stop: paused %b busy %b exp 0 0", paused, busy); end
  endtask

  task automatic test_timeout;
    bit ok; int w; logic [15:0] seen;
    bit got_run;
    do_reset;
    pulse_start;
    core_exec($urandom_range(0, 6), 8'h5A, 1'b0, ok, w, seen);
    got_run = 0;
    for (int i = 0; i < 20 && !got_run; i++) begin
      if (core_run === 1'b1) got_run = 1; else tick;
    end
    n_cmp++; if (!got_run) begin n_bad++; $display("FAIL tmo_run: no core_run seen"); end
    for (int i = 0; i < TIMEOUT; i++) tick;
    n_cmp++; if (fault !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL tmo_last_exec: fault %b busy %b exp 0 1", fault, busy); end
    tick;
    n_cmp++; if (fault !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL tmo_fault: fault %b busy %b exp 1 0", fault, busy); end
    n_cmp++; if (mem_addr !== 8'h5A || instr_count !== 16'd1) begin n_bad++; $display("FAIL tmo_keep: pc %h count %0d exp 5a 1", mem_addr, instr_count); end
    core_done = 1; tick; core_done = 0; tick;
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky: fault %b exp 1", fault); end
    pulse_start;
    n_cmp++; if (busy !== 1'b1 || fault !== 1'b0 || mem_addr !== 8'h00) begin n_bad++; $display("FAIL tmo_restart: busy %b fault %b pc %h exp 1 0 00", busy, fault, mem_addr); end
    core_exec(TIMEOUT - 1, 8'h33, 1'b0, ok, w, seen);
    n_cmp++; if (!ok || fault !== 1'b0 || instr_count !== 16'd2) begin n_bad++; $display("FAIL tmo_late_done: fault %b count %0d exp 0 2", fault, instr_count); end
    n_cmp++; if (mem_addr !== 8'h33) begin n_bad++; $display("FAIL tmo_late_pc: got %h exp 33", mem_addr); end
    core_exec(0, 8'h34, 1'b1, ok, w, seen);
  endtask

  task automatic test_spurious;
    bit ok; int w; logic [15:0] seen;
    bit got_run;
    do_reset;
    core_done = 1; tick; core_done = 0; tick;
    n_cmp++; if (busy !== 1'b0 || instr_count !== 16'd0 || mem_addr !== 8'h00) begin n_bad++; $display("FAIL spur_idle: busy %b count %0d pc %h exp 0 0 00", busy, instr_count, mem_addr); end
    step_mode = 1;
    pulse_start;
    core_done = 1; next_pc = 8'hEE; tick; core_done = 0;
    core_exec(2, 8'h21, 1'b0, ok, w, seen);
    n_cmp++; if (!ok || instr_count !== 16'd1 || mem_addr !== 8'h21) begin n_bad++; $display("FAIL spur_fetch: count %0d pc %h exp 1 21", instr_count, mem_addr); end
    core_done = 1; next_pc = 8'hEE; tick; tick; core_done = 0; tick;
    n_cmp++; if (paused !== 1'b1 || instr_count !== 16'd1 || mem_addr !== 8'h21) begin n_bad++; $display("FAIL spur_pause: paused %b count %0d pc %h exp 1 1 21", paused, instr_count, mem_addr); end
    // reset while the run pulse is high
    do_reset;
    pulse_start;
    got_run = 0;
    for (int i = 0; i < 20 && !got_run; i++) begin
      if (core_run === 1'b1) got_run = 1; else tick;
    end
    rst_n = 0; #1;
    n_cmp++; if (!got_run || core_run !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_issue: run %b busy %b exp 0 0", core_run, busy); end
    tick; rst_n = 1;
    // reset during EXEC after one commit
    pulse_start;
    core_exec(1, 8'h44, 1'b0, ok, w, seen);
    got_run = 0;
    for (int i = 0; i < 20 && !got_run; i++) begin
      if (core_run === 1'b1) got_run = 1; else tick;
    end
    tick;
    rst_n = 0; #1;
    n_cmp++; if (!got_run || core_run !== 1'b0 || busy !== 1'b0 || mem_addr !== 8'h00 || instr_count !== 16'd0)
      begin n_bad++; $display("FAIL rst_exec: run %b busy %b pc %h count %0d exp 0 0 00 0", core_run, busy, mem_addr, instr_count); end
    tick; rst_n = 1;
  endtask

  task automatic test_random;
    bit ok; int w; logic [15:0] seen;
    logic [7:0] npc;
    int n;
    do_reset;
    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    n = 40;
    pulse_start;
    for (int i = 0; i < n; i++) begin
      npc = 8'($urandom_range(0, 255));
      core_exec($urandom_range(0, 8), npc, (i == n - 1), ok, w, seen);
      n_cmp++; if (!ok || w != int'(1 + MEM_LAT)) begin n_bad++; $display("FAIL rnd_lat[%0d]: ok %0d waited %0d exp %0d", i, ok, w, 1 + MEM_LAT); end
      n_cmp++; if (seen !== mem[exp_pc]) begin n_bad++; $display("FAIL rnd_instr[%0d]: got %h exp %h", i, seen, mem[exp_pc]); end
      exp_pc = npc;
      exp_cnt = exp_cnt + 16'd1;
      n_cmp++; if (mem_addr !== exp_pc || instr_count !== exp_cnt) begin n_bad++; $display("FAIL rnd_commit[%0d]: pc %h count %0d exp %h %0d", i, mem_addr, instr_count, exp_pc, exp_cnt); end
      if (!ok) break;
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rnd_final_stop: busy %b exp 0", busy); end
  endtask

`ifdef BITTY_SEQ_BREAKPOINT_EN
  task automatic test_breakpoint;
    bit ok; int w; logic [15:0] seen;
    do_reset;
    for (int a = 0; a < 8; a++) mem[a] = 16'(16'hB000 + a);
    bp_en = 1; bp_addr = 8'h02;
    pulse_start;
    core_exec(0, 8'h01, 1'b0, ok, w, seen);
    core_exec(1, 8'h02, 1'b0, ok, w, seen);
    tick;
    n_cmp++; if (paused !== 1'b1 || bp_hit !== 1'b1 || instr_count !== 16'd2) begin n_bad++; $display("FAIL bp_pause: paused %b hit %b count %0d exp 1 1 2", paused, bp_hit, instr_count); end
    step = 1; tick; step = 0;
    n_cmp++; if (bp_hit !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL bp_step: hit %b busy %b exp 0 1", bp_hit, busy); end
    core_exec(0, 8'h03, 1'b1, ok, w, seen);
    n_cmp++; if (!ok || seen !== 16'hB002 || mem_addr !== 8'h03 || instr_count !== 16'd3) begin n_bad++; $display("FAIL bp_exec: instr %h pc %h count %0d exp b002 03 3", seen, mem_addr, instr_count); end
    bp_en = 0;
  endtask
`endif

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    test_reset;
    test_latency;
    test_stop;
    test_step;
    test_timeout;
    test_spurious;
    test_random;
`ifdef BITTY_SEQ_BREAKPOINT_EN
    test_breakpoint;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
